// File: rtl/pc_pkg.sv
// pc_pkg: shared next-pc source encoding and default sizing for the pc_sequencer slice
package pc_pkg;
  localparam int ADDR_W_DEF     = 5;
  localparam int RESET_ADDR_DEF = 0;
  typedef enum logic [2:0] {
    SRC_HOLD,
    SRC_SEQ,
    SRC_BR,
    SRC_JMP,
    SRC_RET
  } src_e;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular LIFO return-address stack; a push when full overwrites the oldest entry
module pc_ras #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] data_i,
  output logic [ADDR_W-1:0] top_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              err_o
);
  localparam int PW = $clog2(DEPTH);
  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     sp_q, sp_d;
  logic [PW:0]       cnt_q, cnt_d;
  logic              err_q, err_d;
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign top_o   = mem_q[sp_q - PW'(1)];
  assign err_o   = err_q;
  // pointer wraps freely; the count saturates so a full stack stays full after an overwrite
  always_comb begin
    sp_d  = push_i ? sp_q + PW'(1) : (pop_i && !empty_o) ? sp_q - PW'(1) : sp_q;
    cnt_d = (push_i && !full_o) ? cnt_q + (PW+1)'(1)
          : (!push_i && pop_i && !empty_o) ? cnt_q - (PW+1)'(1) : cnt_q;
    err_d = (push_i && full_o) || (!push_i && pop_i && empty_o);
  end
  // entry storage needs no reset: the count decides what is readable
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[sp_q] <= data_i;
  end
  // pointer, occupancy and error-pulse registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sp_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered fetch PC with branch/jump/stall/handshake and wrap pulse; optional return stack via PC_RAS_EN
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int RESET_ADDR = RESET_ADDR_DEF,
  parameter int RAS_DEPTH  = 4
) (
  input  logic              clkEN,
  input  logic              rstN,
  input  logic              stall,
  input  logic              br_take,
  input  logic [ADDR_W-1:0] br_offset,
  input  logic              jmp_take,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  input  logic              pc_ready,
  output logic              wrap
`ifdef PC_RAS_EN
  ,
  input  logic              call,
  input  logic              ret,
  output logic              ras_err
`endif
);
  logic [ADDR_W-1:0] pc_q, pc_d, ret_pc;
  logic              valid_q, wrap_q, wrap_d, adv, ret_req, jmp_req;
  src_e              src;
  assign adv      = valid_q & ~stall;
  assign pc       = pc_q;
  assign pc_valid = valid_q;
  assign wrap     = wrap_q;
`ifdef PC_RAS_EN
  logic              ras_empty, unused_full;
  logic [ADDR_W-1:0] ras_top;
  assign ret_req = ret;
  assign jmp_req = jmp_take | call;
  assign ret_pc  = ras_empty ? pc_q : ras_top;
  pc_ras #(
    .ADDR_W(ADDR_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i  (clkEN),
    .rst_ni (rstN),
    .push_i (adv & call & ~ret),
    .pop_i  (adv & ret),
    .data_i (pc_q + ADDR_W'(1)),
    .top_o  (ras_top),
    .empty_o(ras_empty),
    .full_o (unused_full),
    .err_o  (ras_err)
  );
`else
  logic unused_depth;
  assign unused_depth = ^RAS_DEPTH;
  assign ret_req      = 1'b0;
  assign jmp_req      = jmp_take;
  assign ret_pc       = pc_q;
`endif
  // pick the next-pc source by priority, then form the address; wrap only on a sequential roll-over
  always_comb begin
    src    = !adv     ? SRC_HOLD
           : ret_req  ? SRC_RET
           : jmp_req  ? SRC_JMP
           : br_take  ? SRC_BR
           : pc_ready ? SRC_SEQ : SRC_HOLD;
    pc_d   = (src == SRC_JMP) ? jmp_addr
           : (src == SRC_BR)  ? pc_q + br_offset
           : (src == SRC_SEQ) ? pc_q + ADDR_W'(1)
           : (src == SRC_RET) ? ret_pc : pc_q;
    wrap_d = (src == SRC_SEQ) && (&pc_q);
  end
  // pc, valid and wrap registers; valid rises on the first edge after reset without moving pc
  always_ff @(posedge clkEN or negedge rstN) begin
    if (!rstN) begin
      pc_q    <= ADDR_W'(RESET_ADDR);
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= 1'b1;
      wrap_q  <= wrap_d;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer (RAS steps only when PC_RAS_EN is defined)
module tb_pc_sequencer;
  logic       clk = 1'b0;
  logic       rst_n, stall, br_take, jmp_take, pc_ready;
  logic [4:0] br_offset, jmp_addr, pc;
  logic       pc_valid, wrap;
  int         checks = 0;
  int         failures = 0;
`ifdef PC_RAS_EN
  logic       call, ret, ras_err;
`endif
  always #5 clk = ~clk;
  pc_sequencer #(.ADDR_W(5), .RESET_ADDR(0), .RAS_DEPTH(4)) dut (
    .clkEN    (clk),
    .rstN     (rst_n),
    .stall    (stall),
    .br_take  (br_take),
    .br_offset(br_offset),
    .jmp_take (jmp_take),
    .jmp_addr (jmp_addr),
    .pc       (pc),
    .pc_valid (pc_valid),
    .pc_ready (pc_ready),
    .wrap     (wrap)
`ifdef PC_RAS_EN
    ,
    .call     (call),
    .ret      (ret),
    .ras_err  (ras_err)
`endif
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_pc(input string tag, input int p, input logic w);
    check({tag, "_pc"}, 32'(pc), 32'(p));
    check({tag, "_wrap"}, 32'(wrap), 32'(w));
  endtask
  initial begin
    rst_n = 1'b0; stall = 1'b0; br_take = 1'b0; jmp_take = 1'b0; pc_ready = 1'b1;
    br_offset = '0; jmp_addr = '0;
`ifdef PC_RAS_EN
    call = 1'b0; ret = 1'b0;
`endif
    #2;
    check("rst_pc", 32'(pc), 0);
    check("rst_valid", 32'(pc_valid), 0);
    check("rst_wrap", 32'(wrap), 0);
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("first_valid", 32'(pc_valid), 1);
    check("first_pc", 32'(pc), 0);
    for (int i = 1; i <= 32; i++) begin
      step();
      chk_pc("seq", i % 32, i == 32);
    end
    step();
    chk_pc("seq_after_wrap", 1, 1'b0);
    for (int i = 2; i <= 10; i++) begin
      step();
      check("to10", 32'(pc), 32'(i));
    end
    br_take = 1'b1; br_offset = 5'b11101;
    step();
    chk_pc("br_10m3", 7, 1'b0);
    br_take = 1'b0; jmp_take = 1'b1; jmp_addr = 5'd2;
    step();
    chk_pc("jmp2", 2, 1'b0);
    jmp_take = 1'b0; br_take = 1'b1;
    step();
    chk_pc("br_2m3", 31, 1'b0);
    br_take = 1'b0;
    step();
    chk_pc("seq_31_0", 0, 1'b1);
    step();
    chk_pc("seq_0_1", 1, 1'b0);
    jmp_take = 1'b1; jmp_addr = 5'd0;
    step();
    chk_pc("jmp_to0", 0, 1'b0);
    br_take = 1'b1; br_offset = 5'd3; jmp_addr = 5'd20;
    step();
    chk_pc("br_jmp", 20, 1'b0);
    stall = 1'b1; jmp_addr = 5'd5;
    step();
    chk_pc("stall1", 20, 1'b0);
    step();
    chk_pc("stall2", 20, 1'b0);
    stall = 1'b0; br_take = 1'b0; jmp_take = 1'b0;
    step();
    chk_pc("unstall", 21, 1'b0);
    jmp_take = 1'b1; jmp_addr = 5'd31;
    step();
    chk_pc("jmp31", 31, 1'b0);
    jmp_take = 1'b0;
    step();
    chk_pc("wrap_pre_stall", 0, 1'b1);
    stall = 1'b1;
    step();
    chk_pc("wrap_stall_drop", 0, 1'b0);
    stall = 1'b0; jmp_take = 1'b1; jmp_addr = 5'd6;
    step();
    chk_pc("jmp6", 6, 1'b0);
    jmp_take = 1'b0; pc_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_pc("notready", 6, 1'b0);
    end
    jmp_take = 1'b1; jmp_addr = 5'd12;
    step();
    chk_pc("jmp_notready", 12, 1'b0);
    jmp_take = 1'b0;
    step();
    chk_pc("hold12", 12, 1'b0);
    pc_ready = 1'b1;
    for (int i = 13; i <= 17; i++) begin
      step();
      chk_pc("to17", i, 1'b0);
    end
    jmp_take = 1'b1; jmp_addr = 5'd25;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pc", 32'(pc), 0);
    check("arst_valid", 32'(pc_valid), 0);
    jmp_take = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rerst_valid", 32'(pc_valid), 1);
    chk_pc("rerst_pc", 0, 1'b0);
    step();
    chk_pc("rerst_seq", 1, 1'b0);
`ifdef PC_RAS_EN
    jmp_take = 1'b1; jmp_addr = 5'd3;
    step();
    chk_pc("jmp3", 3, 1'b0);
    jmp_take = 1'b0; call = 1'b1; jmp_addr = 5'd16;
    step();
    chk_pc("call16", 16, 1'b0);
    check("call16_err", 32'(ras_err), 0);
    call = 1'b0; ret = 1'b1;
    step();
    chk_pc("ret4", 4, 1'b0);
    check("ret4_err", 32'(ras_err), 0);
    ret = 1'b0; call = 1'b1;
    for (int i = 0; i < 5; i++) begin
      jmp_addr = 5'(8 + i);
      step();
      check("nest_pc", 32'(pc), 32'(8 + i));
      check("nest_err", 32'(ras_err), 32'(i == 4));
    end
    call = 1'b0; ret = 1'b1;
    step();
    check("ret_5th", 32'(pc), 12);
    check("ret_5th_err", 32'(ras_err), 0);
    for (int i = 11; i >= 9; i--) begin
      step();
      check("ret_chain", 32'(pc), 32'(i));
      check("ret_chain_err", 32'(ras_err), 0);
    end
    step();
    check("ret_empty_pc", 32'(pc), 9);
    check("ret_empty_err", 32'(ras_err), 1);
    ret = 1'b0;
    step();
    check("after_empty_pc", 32'(pc), 10);
    check("after_empty_err", 32'(ras_err), 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter unit that generates the next fetch address each cycle.
- Adds the following to plain increment: relative branch, absolute jump, stall, a valid/ready handshake toward instruction memory, and a registered wrap indication.
- Sits between the control unit (redirect requests) and instruction memory (address consumer). It replaces the fixed 5-bit increment stage.

Parameters:
- ADDR_W, 5, PC width in bits; all PC arithmetic is modulo 2^ADDR_W.
- RESET_ADDR, 0, PC value loaded during reset.
- RAS_DEPTH, 4, return-address-stack entries (used only with PC_RAS_EN); power of two, >=2.

Ports:
- clkEN  in  1  clock; all state updates on its rising edge.
- rstN  in  1  asynchronous, active-low reset.
- stall  in  1  freezes PC and all state when high, including redirects.
- br_take  in  1  take relative branch this cycle.
- br_offset  in  ADDR_W  signed two's-complement offset, relative to current pc.
- jmp_take  in  1  take absolute jump this cycle.
- jmp_addr  in  ADDR_W  jump target.
- pc  out  ADDR_W  current fetch address (registered).
- pc_valid  out  1  pc is presentable to memory.
- pc_ready  in  1  memory accepts pc this cycle.
- wrap  out  1  one-cycle pulse: the last sequential advance went from 2^ADDR_W-1 to 0.
- call  in  1  (PC_RAS_EN only) push pc+1, then jump to jmp_addr.
- ret  in  1  (PC_RAS_EN only) pop top of stack into pc.
- ras_err  out  1  (PC_RAS_EN only) one-cycle pulse on pop-when-empty or push-when-full.

Behaviour:
- Reset (rstN=0, asynchronous):
  - pc=RESET_ADDR, pc_valid=0, wrap=0.
  - Stack empty, ras_err=0.
- First rising edge after rstN rises: pc_valid=1. pc_valid stays 1 until the next reset. pc does not change on that edge.
- Next-pc select, evaluated only when pc_valid=1 and stall=0. Priority high to low:
  - ret (RAS builds only).
  - jmp_take/call: pc <= jmp_addr.
  - br_take: pc <= pc + br_offset (sign-extended, truncated to ADDR_W).
  - Accept (pc_valid & pc_ready): pc <= pc + 1, modulo 2^ADDR_W.
  - Otherwise: hold.
- Redirects take effect whether or not pc_ready is high. The pending address is discarded, not presented later.
- Latency: the new pc is visible one cycle after the request edge. There is no combinational path from inputs to pc.
- stall=1 overrides everything, including redirects; pc, stack and wrap are held. wrap still deasserts after its single cycle.
- wrap: registered.
  - Asserted for exactly one cycle after a sequential advance from all-ones to 0.
  - Redirects that land on 0 do not assert it.
  - Branch arithmetic overflow does not assert it.
- Simultaneous br_take and jmp_take: jump wins, branch is ignored.
- Reset mid-operation: immediate return to reset values. Any in-flight redirect is lost.

Optional Feature:
- Macro: PC_RAS_EN.
- Defined:
  - Ports call, ret and ras_err exist; a RAS_DEPTH-entry LIFO return-address stack is built.
  - call pushes (pc+1) mod 2^ADDR_W and loads jmp_addr.
  - ret pops the top of stack into pc.
  - Push when full: the oldest entry is overwritten (circular), ras_err pulses, and the push still completes.
  - Pop when empty: pc holds, ras_err pulses.
  - call with ret: ret wins; call is ignored.
- Undefined: the ports are absent, no stack logic is built, and priority starts at jmp_take.

Decomposition:
- Shared package pc_pkg:
  - next-pc source enum: SRC_HOLD, SRC_SEQ, SRC_BR, SRC_JMP, SRC_RET.
  - Default ADDR_W and RESET_ADDR constants.
- One natural sub-module, pc_ras: the circular LIFO with push/pop/full/empty/err, instantiated only under PC_RAS_EN.

Test Plan:
- Reset then pc_ready=1 constant, ADDR_W=5 → pc_valid rises one edge after rstN; pc runs 0,1,…,31,0. wrap is high for exactly the cycle where pc=0 after 31.
- At pc=10, br_take=1 with br_offset=5'b11101 (−3) → pc=7 next cycle. At pc=2, offset −3 → pc=31, wrap stays 0.
- br_take and jmp_take together, jmp_addr=20, stall=0 → pc=20. Same with stall=1 → pc unchanged. After stall drops, pc advances normally.
- pc_ready=0 for 3 cycles at pc=6 → pc holds 6. jmp_take with jmp_addr=12 during that wait → pc=12 regardless of pc_ready.
- rstN pulsed low mid-sequence at pc=17 → pc=0 and pc_valid=0 asynchronously, before the next edge.
- (PC_RAS_EN, RAS_DEPTH=4) call at pc=3 to 16, then ret → pc=4.
  - 5 nested calls → ras_err pulses on the 5th; the following ret returns the 5th call's address.
  - ret when empty → pc holds, ras_err pulses.
